xorshift_job_arbiter: RTL

- Shares one xorshift32 generator datapath between NUM_REQ job requesters, all in one clock domain.
- A job is a seed plus a length. The block grants jobs round-robin, loads the seed, and streams `len` random words toward the async FIFO write side.
- It stalls on `fifo_full` and reports job completion.
- It sits in the generator (clk2) domain, between the synchronized seed sources and the FIFO write port.

---
 rtl/xorshift_job_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/xorshift_job_arbiter.sv
// xorshift_job_arbiter
// Round-robin arbiter that shares one xorshift32 generator between NUM_REQ
// job requesters and streams each job's words toward an async FIFO write port.
// A job is a 32-bit seed plus a CNT_W-bit length (0 means 2^CNT_W words).
// Optional build macro: XORSHIFT_ZERO_SEED_GUARD_EN -- when defined, a granted
// seed of zero is replaced by one so the generator never locks up at zero.
// req_ready, out_valid, out_data and done are combinational by design so the
// grant and the write strobe land in the same cycle as the decision.

module xorshift_job_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [32*NUM_REQ-1:0]    req_seed,
  input  logic [CNT_W*NUM_REQ-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DBL_W  = 2 * NUM_REQ;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [WORD_W-1:0]   lfsr_q;
  logic [WORD_W-1:0]   lfsr_d;
  logic [ID_W-1:0]     out_id_d;
  logic                busy_d;

  logic [DBL_W-1:0]    req_dbl;
  logic [NUM_REQ-1:0]  req_rot;
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [WORD_W-1:0]   seed_sel;
  logic [CNT_W-1:0]    len_sel;
  logic [WORD_W-1:0]   seed_load;
  logic [WORD_W-1:0]   nxt;

  // One xorshift32 step (13 / 17 / 5), all shifts truncated to 32 bits.
  function automatic logic [WORD_W-1:0] xorshift32(input logic [WORD_W-1:0] a);
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    b = a ^ (a << 13);
    c = b ^ (b >> 17);
    return c ^ (c << 5);
  endfunction

  assign nxt = xorshift32(lfsr_q);

  // Rotate requests so bit 0 is the requester just after rr_ptr, then pick the first.
  always_comb begin
    req_dbl     = {req_valid, req_valid};
    req_rot     = NUM_REQ'(req_dbl >> (32'(rr_ptr_q) + 32'd1));
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_rot[k]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((32'(rr_ptr_q) + 32'd1 + k) % NUM_REQ);
      end
    end
  end

  // Select the granted requester's seed and length from the packed buses.
  always_comb begin
    seed_sel = '0;
    len_sel  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        seed_sel = req_seed[k*WORD_W +: WORD_W];
        len_sel  = req_len[k*CNT_W +: CNT_W];
      end
    end
  end

  // Seed conditioning at load time.
`ifdef XORSHIFT_ZERO_SEED_GUARD_EN
  assign seed_load = (seed_sel == '0) ? WORD_W'(1) : seed_sel;
`else
  assign seed_load = seed_sel;
`endif

  // Next-state, datapath next values and combinational handshake outputs.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    out_id_d  = out_id;
    busy_d    = busy;
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (grant_found) begin
          req_ready = NUM_REQ'(1) << grant_idx;
          lfsr_d    = seed_load;
          cnt_d     = len_sel;
          out_id_d  = grant_idx;
          rr_ptr_d  = grant_idx;
          state_d   = RUN;
          busy_d    = 1'b1;
        end
      end

      RUN: begin
        out_data = nxt;
        if (!fifo_full) begin
          out_valid = 1'b1;
          lfsr_d    = nxt;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            done    = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs; rr_ptr resets so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      cnt_q    <= '0;
      lfsr_q   <= '0;
      out_id   <= '0;
      busy     <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      out_id   <= out_id_d;
      busy     <= busy_d;
    end
  end

endmodule
